// File: rtl/capture_ctrl.sv
// Capture-RAM write controller: fills a circular buffer with pre-trigger
// history, waits for a trigger, then stores a fixed number of post-trigger words.
module capture_ctrl #(
  parameter int unsigned AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    smpl,
  input  logic          wrt_smpl,
  input  logic          run,
  input  logic          trig_in,
  input  logic [AW-1:0] trig_pos,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [7:0]    wdata,
  output logic          armed,
  output logic          capture_done,
  output logic [AW-1:0] trig_addr
);

  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [AW-1:0] ptr, ptr_nx;
  logic [AW-1:0] tpos, tpos_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] pre_len;
  logic          tpos_zero;
  logic          do_write;
  logic          we_nx;
  logic [AW-1:0] waddr_nx;
  logic [7:0]    wdata_nx;
  logic [AW-1:0] trig_addr_nx;

  // Pre-trigger depth; trig_pos=0 naturally yields the full 2**AW words
  assign pre_len   = {1'b1, {AW{1'b0}}} - CW'(tpos);
  assign cnt_inc   = cnt + CW'(1);
  assign tpos_zero = (tpos == '0);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      tpos         <= '0;
      cnt          <= '0;
      we           <= 1'b0;
      waddr        <= '0;
      wdata        <= '0;
      trig_addr    <= '0;
      armed        <= 1'b0;
      capture_done <= 1'b0;
    end else begin
      state        <= state_nx;
      ptr          <= ptr_nx;
      tpos         <= tpos_nx;
      cnt          <= cnt_nx;
      we           <= we_nx;
      waddr        <= waddr_nx;
      wdata        <= wdata_nx;
      trig_addr    <= trig_addr_nx;
      armed        <= (state_nx == ARMED);
      capture_done <= (state_nx == DONE);
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (run) state_nx = PRE;
      end
      PRE: begin
        if (!run)                                  state_nx = IDLE;
        else if (wrt_smpl && (cnt_inc == pre_len)) state_nx = ARMED;
      end
      ARMED: begin
        if (!run) begin
          state_nx = IDLE;
        end else if (trig_in) begin
          if (tpos_zero)                             state_nx = DONE;
          else if (wrt_smpl && (tpos == AW'(1)))     state_nx = DONE;
          else                                       state_nx = POST;
        end
      end
      POST: begin
        if (!run)                                    state_nx = IDLE;
        else if (wrt_smpl && (cnt_inc == CW'(tpos))) state_nx = DONE;
      end
      DONE: begin
        if (!run) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Write path, counters and trigger-address capture
  always_comb begin
    we_nx        = 1'b0;
    waddr_nx     = waddr;
    wdata_nx     = wdata;
    ptr_nx       = ptr;
    cnt_nx       = cnt;
    tpos_nx      = tpos;
    trig_addr_nx = trig_addr;

    // A zero-length post window must not overwrite the oldest pre-trigger word
    do_write = 1'b0;
    if (run && wrt_smpl) begin
      case (state)
        PRE, POST: do_write = 1'b1;
        ARMED:     do_write = !(trig_in && tpos_zero);
        default:   do_write = 1'b0;
      endcase
    end

    if (do_write) begin
      we_nx    = 1'b1;
      waddr_nx = ptr;
      wdata_nx = smpl;
      ptr_nx   = ptr + AW'(1);
    end

    case (state)
      IDLE: begin
        if (run) begin
          ptr_nx   = '0;
          waddr_nx = '0;
          cnt_nx   = '0;
          tpos_nx  = trig_pos;
        end
      end
      PRE: begin
        if (do_write) cnt_nx = (cnt_inc == pre_len) ? '0 : cnt_inc;
      end
      ARMED: begin
        if (run && trig_in) begin
          trig_addr_nx = ptr;
          cnt_nx       = do_write ? CW'(1) : '0;
        end
      end
      POST: begin
        if (do_write) cnt_nx = cnt_inc;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 SHALL have parameter AW, default 9, meaning capture RAM address width; buffer depth = 2**AW words.
REQ-002 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port smpl  input  8  packed 4-deep sample word from the channel sampler, {H2,L2,H3,L3,H4,L4,H5,L5}.
REQ-005 SHALL have port wrt_smpl  input  1  one-clk strobe; smpl is valid this cycle.
REQ-006 SHALL have port run  input  1  level; 1 = capture enabled, 0 = abort/return to idle.
REQ-007 SHALL have port trig_in  input  1  trigger event from trigger logic, sampled only in ARMED.
REQ-008 SHALL have port trig_pos  input  AW  number of post-trigger words to store; sampled on leaving IDLE.
REQ-009 SHALL have port we  output  1  RAM write enable.
REQ-010 SHALL have port waddr  output  AW  RAM write address.
REQ-011 SHALL have port wdata  output  8  RAM write data.
REQ-012 SHALL have port armed  output  1  high in ARMED state.
REQ-013 SHALL have port capture_done  output  1  high in DONE state.
REQ-014 SHALL have port trig_addr  output  AW  address of the first post-trigger word.

Function
REQ-015 SHALL implement states IDLE, PRE, ARMED, POST, DONE.
REQ-016 SHALL latch trig_pos into an internal register on IDLE->PRE; later trig_pos changes ignored until next IDLE.
REQ-017 IDLE: no writes; run=1 -> PRE on next clk, waddr cleared to 0, pre-count cleared.
REQ-018 Writes (PRE/ARMED/POST): on wrt_smpl=1, we=1, wdata=smpl, waddr=current pointer, registered, 1 clk latency; pointer increments after each write, wraps 2**AW-1 -> 0.
REQ-019 PRE: count writes; after (2**AW - latched trig_pos) writes -> ARMED; if that quantity is 0 (trig_pos=0 wraps) treat as 2**AW.
REQ-020 ARMED: keep writing (circular overwrite); trig_in=1 -> POST; if trig_in and wrt_smpl same clk, that sample is the first post-trigger word and its address is captured in trig_addr.
REQ-021 If trig_in without wrt_smpl, trig_addr = pointer value of the next write.
REQ-022 trig_in outside ARMED SHALL be ignored (no state change, trig_addr unchanged).
REQ-023 POST: after latched trig_pos writes (counting the trigger write) -> DONE; latched trig_pos=0 -> DONE on the trigger cycle with no post words counted.
REQ-024 DONE: we held 0, pointer and trig_addr frozen; run=0 -> IDLE.
REQ-025 run=0 in PRE/ARMED/POST SHALL abort to IDLE next clk; no write that cycle; trig_addr unchanged.
REQ-026 we SHALL never be asserted in IDLE or DONE, nor on a cycle without wrt_smpl one clk earlier.
REQ-027 Final buffer SHALL hold exactly 2**AW - trig_pos pre-trigger words older than trig_addr and trig_pos words from trig_addr onward.

Reset
REQ-028 rst_n=0 SHALL asynchronously force IDLE, we=0, waddr=0, wdata=0, armed=0, capture_done=0, trig_addr=0, all counters 0.
REQ-029 Reset release SHALL take effect on the first posedge clk with rst_n=1; reset mid-capture discards all progress.

Verification
REQ-030 AW=4, trig_pos=4, run=1, wrt_smpl every clk: armed asserts after 12 writes; trig_in at write 20 -> trig_addr=4, capture_done after 4 more writes, last waddr=7.
REQ-031 trig_in asserted during PRE (write 5) -> ignored, state stays PRE, trig_addr=0.
REQ-032 trig_pos=0, AW=4: armed after 16 writes; trig_in -> DONE next clk, no post writes, trig_addr=next pointer.
REQ-033 wrt_smpl every 3rd clk: we pulses follow 1 clk later, wdata equals smpl of strobe cycle (e.g. 8'hA5 -> wdata 8'hA5).
REQ-034 run dropped in POST after 2 post writes -> IDLE next clk, we=0, capture_done=0; run re-raised restarts at waddr=0.
REQ-035 rst_n pulsed low in ARMED between clock edges -> outputs zero immediately, IDLE after release.
